// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM state type, op codes and IEEE-754 single field widths
// for the FP add/sub request controller.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fpu_state_e;

    localparam logic FPU_OP_ADD = 1'b0;
    localparam logic FPU_OP_SUB = 1'b1;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

endpackage

// File: rtl/fpu_req_ctrl_if.sv
// fpu_req_ctrl_if: request, FP-unit and response channels of the controller;
// master is the controller side, slave is its surroundings.
interface fpu_req_ctrl_if;
    import fpu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [FP_W-1:0] req_a;
    logic [FP_W-1:0] req_b;
    logic            fpu_start;
    logic            fpu_op;
    logic [FP_W-1:0] fpu_a;
    logic [FP_W-1:0] fpu_b;
    logic            fpu_busy;
    logic            fpu_ready;
    logic [FP_W-1:0] fpu_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [FP_W-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b, fpu_busy, fpu_ready, fpu_data, rsp_ready,
        output req_ready, fpu_start, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, fpu_busy, fpu_ready, fpu_data, rsp_ready,
        input  req_ready, fpu_start, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/fpu_rsp_fifo.sv
// fpu_rsp_fifo: synchronous response FIFO with wrap-bit pointers; head entry
// reads as zero when empty.
module fpu_rsp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wp[AW-1:0]] <= wdata;
    end

    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);
    assign rdata = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: issues one FP add/sub at a time and queues results downstream.
// Define FPU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles with an error entry.
module fpu_req_ctrl
    import fpu_pkg::*;
#(
    parameter int RSP_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clock,
    input  logic           reset,
    fpu_req_ctrl_if.master bus
);
`ifdef FPU_TIMEOUT_EN
    localparam int RW    = FP_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC) > 8 ? $clog2(TIMEOUT_CYC) : 8;
`else
    localparam int RW    = FP_W;
`endif

    fpu_state_e      state;
    fpu_state_e      nxt;
    logic            rdy;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            timeout;
    logic            op_q;
    logic [FP_W-1:0] a_q;
    logic [FP_W-1:0] b_q;
    logic [RW-1:0]   wdata;
    logic [RW-1:0]   rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= nxt;
            if (rdy && bus.req_valid) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
        end
    end

    // Only IDLE accepts, so no op is in flight there and a free slot is enough to reserve one.
    always_comb begin
        nxt  = state;
        rdy  = 1'b0;
        push = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy = ~reset & ~full & ~bus.fpu_busy & ~bus.fpu_ready;
                nxt = (rdy && bus.req_valid) ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: nxt = ST_WAIT;
            ST_WAIT: begin
                push = bus.fpu_ready | timeout;
                nxt  = push ? ST_IDLE : ST_WAIT;
            end
            default: nxt = ST_IDLE;
        endcase
    end

`ifdef FPU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
    end

    // A ready on the timeout edge still wins because the entry takes the unit's data.
    assign timeout = (state == ST_WAIT) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign wdata   = {~bus.fpu_ready, bus.fpu_ready ? bus.fpu_data : {FP_W{1'b0}}};
    assign bus.rsp_err = rdata[FP_W];
`else
    assign timeout = 1'b0;
    assign wdata   = bus.fpu_data;
    assign bus.rsp_err = 1'b0;
`endif

    assign pop           = ~empty & bus.rsp_ready;
    assign bus.req_ready = rdy;
    assign bus.fpu_start = (state == ST_ISSUE);
    assign bus.fpu_op    = op_q;
    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.rsp_valid = ~empty;
    assign bus.rsp_data  = rdata[FP_W-1:0];

    fpu_rsp_fifo #(
        .W     (RW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// tb_fpu_req_ctrl: FP-unit stub (result = a ^ b, programmable latency) plus a
// cycle-level transaction model of accept/issue/complete/pop.
module tb_fpu_req_ctrl;
    import fpu_pkg::*;

    localparam int D   = 4;
    localparam int TOC = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fpu_req_ctrl_if bus();

    fpu_req_ctrl #(.RSP_DEPTH(D), .TIMEOUT_CYC(TOC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model state
    bit          inflight, issue_now;
    int          wcyc, occ, acc_cnt, rsp_cnt, n_start;
    logic        hop;
    logic [31:0] ha, hb;
    logic [32:0] q[$];

    // stub / driver controls
    int lat_fix = 0;
    bit inject  = 0;
    bit rnd_on  = 0;

    always @(negedge clock) begin
        if (!reset) begin
            bit done;
            logic [32:0] head;
            check("start", bus.fpu_start, issue_now);
            check("req_ready", bus.req_ready, !inflight && occ < D && !bus.fpu_busy && !bus.fpu_ready);
            check("rsp_valid", bus.rsp_valid, occ > 0);
            if (bus.fpu_start) n_start++;
            if (occ == 0) check("rsp_empty", {bus.rsp_err, bus.rsp_data}, 33'h0);
            if (occ > 0 && bus.rsp_ready) begin
                head = q.pop_front();
                check("rsp", {bus.rsp_err, bus.rsp_data}, head);
                rsp_cnt++;
                occ--;
            end
            if (inflight) check("hold", {bus.fpu_op, bus.fpu_a, bus.fpu_b}, {hop, ha, hb});
            done = 0;
            if (inflight && !issue_now) begin
                wcyc++;
                if (bus.fpu_ready) begin
                    q.push_back({1'b0, ha ^ hb});
                    done = 1;
                end
`ifdef FPU_TIMEOUT_EN
                else if (wcyc == TOC) begin
                    q.push_back({1'b1, 32'h0});
                    done = 1;
                end
`endif
            end
            if (done) begin
                inflight = 0;
                occ++;
            end
            issue_now = bus.req_valid && bus.req_ready;
            if (issue_now) begin
                inflight = 1;
                wcyc = 0;
                hop = bus.req_op;
                ha = bus.req_a;
                hb = bus.req_b;
                acc_cnt++;
            end
        end
    end

    // FP-unit stub: samples start at negedge, updates #1 after the rising edge
    initial begin
        bit st, active;
        int k, lat;
        logic [31:0] sa, sb, rd;
        active = 0; k = 0; lat = 1; rd = '0;
        bus.fpu_busy = 0; bus.fpu_ready = 0; bus.fpu_data = '0;
        forever begin
            @(negedge clock);
            st = bus.fpu_start; sa = bus.fpu_a; sb = bus.fpu_b;
            @(posedge clock);
            #1;
            bus.fpu_ready = 0;
            if (reset) begin
                active = 0;
                bus.fpu_busy = 0;
            end else begin
                if (st) begin
                    active = 1; bus.fpu_busy = 1; k = 0;
                    lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 8));
                    rd = sa ^ sb;
                end
                if (active) begin
                    k++;
                    if (k == lat) begin
                        bus.fpu_ready = 1; bus.fpu_busy = 0; bus.fpu_data = rd; active = 0;
                    end
                end
                if (inject) begin
                    bus.fpu_ready = 1; bus.fpu_data = 32'hDEADBEEF; inject = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_on) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_op    = 1'($urandom_range(0, 1));
                bus.req_a     = $urandom;
                bus.req_b     = $urandom;
                bus.rsp_ready = $urandom_range(0, 3) != 0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic op, input logic [31:0] a, input logic [31:0] b);
        int base;
        bit ok;
        base = acc_cnt;
        ok = 0;
        bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick;
            ok = acc_cnt != base;
        end
        bus.req_valid = 0;
        if (!ok) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp;
        for (int i = 0; i < 200 && !bus.rsp_valid; i++) tick;
        if (!bus.rsp_valid) check("rsp_wait_timeout", 0, 1);
    endtask

    task automatic drain;
        bus.rsp_ready = 1;
        for (int i = 0; i < 500 && (inflight || occ > 0); i++) tick;
        check("drain", 65'(inflight) + 65'(occ), 0);
        bus.rsp_ready = 0;
    endtask

    task automatic check_reset_outs;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_start", bus.fpu_start, 0);
        check("rst_fpu_opnd", {bus.fpu_op, bus.fpu_a, bus.fpu_b}, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    endtask

    initial begin
        int base, base_s;
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 0;
        repeat (3) tick;
        check_reset_outs;
        #2 reset = 0;

        // single op
        lat_fix = 5;
        base_s = n_start;
        do_req(FPU_OP_ADD, 32'h3F800000, 32'h40000000);
        wait_rsp;
        check("t1_data", {bus.rsp_err, bus.rsp_data}, {1'b0, 32'h7F800000});
        check("t1_starts", n_start - base_s, 1);
        bus.rsp_ready = 1;
        tick;
        bus.rsp_ready = 0;
        tick;

        // back-to-back with random latency
        lat_fix = 0;
        bus.rsp_ready = 1;
        base = rsp_cnt;
        for (int i = 0; i < 8; i++) do_req(1'($urandom_range(0, 1)), $urandom, $urandom);
        drain;
        check("b2b_count", rsp_cnt - base, 8);

        // backpressure: FIFO fills at D entries
        lat_fix = 2;
        base = acc_cnt;
        bus.req_valid = 1;
        for (int i = 0; i < 150; i++) begin
            bus.req_a = $urandom; bus.req_b = $urandom;
            tick;
        end
        check("bp_accepts", acc_cnt - base, D);
        bus.rsp_ready = 1;
        tick;
        bus.rsp_ready = 0;
        for (int i = 0; i < 60; i++) begin
            bus.req_a = $urandom; bus.req_b = $urandom;
            tick;
        end
        check("bp_one_more", acc_cnt - base, D + 1);
        bus.req_valid = 0;
        drain;

        // pointer wrap over at least 20 ops with random backpressure
        lat_fix = 0;
        base = rsp_cnt;
        rnd_on = 1;
        for (int i = 0; i < 3000 && (rsp_cnt - base) < 20; i++) tick;
        rnd_on = 0;
        bus.req_valid = 0;
        tick;
        drain;
        check("wrap_count_ok", (rsp_cnt - base) >= 20, 1);

        // reset in WAIT
        lat_fix = 10;
        do_req(FPU_OP_SUB, 32'h12345678, 32'h0F0F0F0F);
        repeat (4) tick;
        #2 reset = 1;
        #1;
        check_reset_outs;
        inflight = 0; issue_now = 0; occ = 0; q.delete();
        repeat (2) @(posedge clock);
        #3 reset = 0;
        repeat (15) tick;
        check("rst_no_rsp", bus.rsp_valid, 0);
        lat_fix = 3;
        base = rsp_cnt;
        do_req(FPU_OP_ADD, 32'hA5A5A5A5, 32'h00FF00FF);
        drain;
        check("rst_recover", rsp_cnt - base, 1);

        // stray ready while idle
        inject = 1;
        repeat (4) tick;
        check("stray_no_push", bus.rsp_valid, 0);
        check("stray_idle", bus.req_ready, 1);

`ifdef FPU_TIMEOUT_EN
        lat_fix = 70;
        do_req(FPU_OP_ADD, 32'h11111111, 32'h22222222);
        wait_rsp;
        check("to_err", {bus.rsp_err, bus.rsp_data}, {1'b1, 32'h0});
        bus.rsp_ready = 1;
        tick;
        bus.rsp_ready = 0;
        repeat (12) tick;
        check("to_late_drop", bus.rsp_valid, 0);
        lat_fix = 64;
        do_req(FPU_OP_SUB, 32'h33333333, 32'h0000FFFF);
        wait_rsp;
        check("to_edge_ok", {bus.rsp_err, bus.rsp_data}, {1'b0, 32'h3333CCCC});
        drain;
`endif

        // longer random run
        lat_fix = 0;
        rnd_on = 1;
        repeat (1500) tick;
        rnd_on = 0;
        bus.req_valid = 0;
        tick;
        drain;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
